// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: request/lock/grant bundle between the bus masters and the arbiter.
interface bus_arbiter_if #(
    parameter int MASTER_CH = 4,
    parameter int OWNER_W   = 2
);
    logic [MASTER_CH-1:0] Req_;
    logic [MASTER_CH-1:0] Lock_;
    logic [MASTER_CH-1:0] Grnt_;
    logic [OWNER_W-1:0]   Owner;
    logic                 OwnerValid;
    modport master (output Req_, Lock_, input Grnt_, Owner, OwnerValid);
    modport slave  (input Req_, Lock_, output Grnt_, Owner, OwnerValid);
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin system bus arbiter with hold limit and per-owner lock.
module bus_arbiter #(
    parameter int MASTER_CH = 4,
    parameter int OWNER_W   = 2,
    parameter int MAX_HOLD  = 16,
    parameter int HOLD_W    = 4
) (
    input  logic          clk,
    input  logic          reset_,
    bus_arbiter_if.slave  bus
);
    typedef enum logic {IDLE, OWN} state_t;
    state_t               state;
    logic [HOLD_W-1:0]    hold;
    logic [OWNER_W-1:0]   last, base, pick, idx;
    logic [MASTER_CH-1:0] req, others;
    logic                 found;
    assign req = ~bus.Req_;
    // The current owner is excluded, so found doubles as "another master is requesting".
    always_comb begin
        others = (state == OWN) ? req & ~(MASTER_CH'(1) << bus.Owner) : req;
        base = (state == OWN) ? bus.Owner : last;
        pick = base;
        idx = base;
        found = 1'b0;
        for (int k = 1; k <= MASTER_CH; k++) begin
            idx = OWNER_W'((int'(base) + k) % MASTER_CH);
            if (!found && others[idx]) begin
                pick = idx;
                found = 1'b1;
            end
        end
    end
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state          <= IDLE;
            bus.Grnt_      <= '1;
            bus.Owner      <= '0;
            bus.OwnerValid <= 1'b0;
            hold           <= '0;
            last           <= OWNER_W'(MASTER_CH - 1);
        end else if (state == IDLE) begin
            if (found) begin
                state          <= OWN;
                bus.Grnt_      <= ~(MASTER_CH'(1) << pick);
                bus.Owner      <= pick;
                bus.OwnerValid <= 1'b1;
                hold           <= '0;
            end
        end else if (!req[bus.Owner] || (found && bus.Lock_[bus.Owner] && hold == HOLD_W'(MAX_HOLD - 1))) begin
            last      <= bus.Owner;
            hold      <= '0;
            state     <= found ? OWN : IDLE;
            bus.Grnt_ <= found ? ~(MASTER_CH'(1) << pick) : '1;
            bus.Owner <= found ? pick : bus.Owner;
            bus.OwnerValid <= found;
        end else begin
            hold <= !found ? '0 : (hold == HOLD_W'(MAX_HOLD - 1)) ? hold : hold + 1'b1;
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: vector table, corner sequences and random run against a reference model.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic reset_ = 1'b0;
    always #5 clk = ~clk;

    bus_arbiter_if #(.MASTER_CH(4), .OWNER_W(2)) b4();
    bus_arbiter_if #(.MASTER_CH(3), .OWNER_W(2)) b3();

    bus_arbiter #(.MASTER_CH(4), .OWNER_W(2), .MAX_HOLD(16), .HOLD_W(4))
        dut4 (.clk(clk), .reset_(reset_), .bus(b4));
    bus_arbiter #(.MASTER_CH(3), .OWNER_W(2), .MAX_HOLD(16), .HOLD_W(4))
        dut3 (.clk(clk), .reset_(reset_), .bus(b3));

    typedef struct {int own; int last; int hold; int out;} mst_t;
    typedef struct {bit rst; logic [3:0] req; logic [3:0] lock; logic [3:0] grnt; int owner; bit valid;} vec_t;

    mst_t m[2];
    int   nch[2] = '{4, 3};
    int   n_vec = 0;
    int   n_bad = 0;
    vec_t tbl[7];

    task automatic check(string name, int act, int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) m[i] = '{-1, nch[i] - 1, 0, 0};
    endtask

    // Reference: owner as an integer (-1 = none), search by modular arithmetic.
    task automatic mstep(int i, logic [3:0] req, logic [3:0] lock);
        int n = nch[i];
        int pick = -1;
        int base = (m[i].own >= 0) ? m[i].own : m[i].last;
        for (int k = 1; k <= n; k++) begin
            int c = (base + k) % n;
            if (pick < 0 && c != m[i].own && !req[c]) pick = c;
        end
        if (m[i].own < 0) begin
            if (pick >= 0) begin
                m[i].own = pick;
                m[i].out = pick;
                m[i].hold = 0;
            end
        end else if (req[m[i].own] || (pick >= 0 && lock[m[i].own] && m[i].hold == 15)) begin
            m[i].last = m[i].own;
            m[i].hold = 0;
            m[i].own = pick;
            if (pick >= 0) m[i].out = pick;
        end else begin
            m[i].hold = (pick < 0) ? 0 : (m[i].hold < 15 ? m[i].hold + 1 : 15);
        end
    endtask

    task automatic mcheck(int i);
        int all = (1 << nch[i]) - 1;
        int eg = (m[i].own < 0) ? all : (all & ~(1 << m[i].own));
        if (i == 0) begin
            check("model_grnt4", int'(b4.Grnt_), eg);
            check("model_owner4", int'(b4.Owner), m[0].out);
            check("model_valid4", int'(b4.OwnerValid), int'(m[0].own >= 0));
        end else begin
            check("model_grnt3", int'(b3.Grnt_), eg);
            check("model_owner3", int'(b3.Owner), m[1].out);
            check("model_valid3", int'(b3.OwnerValid), int'(m[1].own >= 0));
        end
    endtask

    task automatic cyc(logic [3:0] r4, logic [3:0] l4, logic [2:0] r3, logic [2:0] l3);
        b4.Req_ = r4;
        b4.Lock_ = l4;
        b3.Req_ = r3;
        b3.Lock_ = l3;
        @(posedge clk);
        mstep(0, r4, l4);
        mstep(1, {1'b1, r3}, {1'b1, l3});
        #1;
        mcheck(0);
        mcheck(1);
    endtask

    task automatic do_reset();
        b4.Req_ = 4'hf;
        b4.Lock_ = 4'hf;
        b3.Req_ = 3'h7;
        b3.Lock_ = 3'h7;
        reset_ = 1'b0;
        mreset();
        @(posedge clk);
        #1;
        reset_ = 1'b1;
    endtask

    initial begin
        logic [3:0] r4, l4;
        logic [2:0] r3, l3;
        tbl[0] = '{1'b1, 4'b1110, 4'hf, 4'b1110, 0, 1'b1};
        tbl[1] = '{1'b0, 4'b1111, 4'hf, 4'b1111, 0, 1'b0};
        tbl[2] = '{1'b1, 4'b0000, 4'hf, 4'b1110, 0, 1'b1};
        tbl[3] = '{1'b0, 4'b0001, 4'hf, 4'b1101, 1, 1'b1};
        tbl[4] = '{1'b0, 4'b0010, 4'hf, 4'b1011, 2, 1'b1};
        tbl[5] = '{1'b0, 4'b0100, 4'hf, 4'b0111, 3, 1'b1};
        tbl[6] = '{1'b0, 4'b1000, 4'hf, 4'b1110, 0, 1'b1};

        do_reset();
        check("rst_grnt", int'(b4.Grnt_), 15);
        check("rst_owner", int'(b4.Owner), 0);
        check("rst_valid", int'(b4.OwnerValid), 0);

        for (int j = 0; j < 7; j++) begin
            if (tbl[j].rst) do_reset();
            cyc(tbl[j].req, tbl[j].lock, 3'h7, 3'h7);
            check($sformatf("tbl%0d_grnt", j), int'(b4.Grnt_), int'(tbl[j].grnt));
            check($sformatf("tbl%0d_owner", j), int'(b4.Owner), tbl[j].owner);
            check($sformatf("tbl%0d_valid", j), int'(b4.OwnerValid), int'(tbl[j].valid));
        end

        do_reset();
        cyc(4'b1110, 4'hf, 3'h7, 3'h7);
        #2 reset_ = 1'b0;
        #1;
        check("async_rst_grnt", int'(b4.Grnt_), 15);
        check("async_rst_valid", int'(b4.OwnerValid), 0);
        do_reset();

        cyc(4'b1001, 4'hf, 3'h7, 3'h7);
        check("hold_first", int'(b4.Owner), 1);
        for (int i = 1; i < 16; i++) begin
            cyc(4'b1001, 4'hf, 3'h7, 3'h7);
            check("hold_keep", int'(b4.Owner), 1);
        end
        cyc(4'b1001, 4'hf, 3'h7, 3'h7);
        check("hold_rot_grnt", int'(b4.Grnt_), 4'b1011);
        check("hold_rot_owner", int'(b4.Owner), 2);

        do_reset();
        for (int i = 0; i < 45; i++) begin
            cyc(4'b1001, 4'b1101, 3'h7, 3'h7);
            check("lock_keep", int'(b4.Owner), 1);
        end
        check("lock_hold_sat", int'(dut4.hold), 15);
        cyc(4'b1001, 4'hf, 3'h7, 3'h7);
        check("unlock_grnt", int'(b4.Grnt_), 4'b1011);
        check("unlock_owner", int'(b4.Owner), 2);

        do_reset();
        cyc(4'b0111, 4'hf, 3'h7, 3'h7);
        check("m3_owner", int'(b4.Owner), 3);
        cyc(4'b1111, 4'hf, 3'h7, 3'h7);
        check("m3_idle_valid", int'(b4.OwnerValid), 0);
        check("m3_idle_owner", int'(b4.Owner), 3);
        cyc(4'b0110, 4'hf, 3'h7, 3'h7);
        check("wrap_grnt", int'(b4.Grnt_), 4'b1110);
        check("wrap_owner", int'(b4.Owner), 0);

        do_reset();
        cyc(4'hf, 4'hf, 3'b000, 3'h7);
        check("ch3_g0", int'(b3.Grnt_), 3'b110);
        cyc(4'hf, 4'hf, 3'b001, 3'h7);
        check("ch3_g1", int'(b3.Grnt_), 3'b101);
        cyc(4'hf, 4'hf, 3'b010, 3'h7);
        check("ch3_g2", int'(b3.Grnt_), 3'b011);
        cyc(4'hf, 4'hf, 3'b100, 3'h7);
        check("ch3_wrap", int'(b3.Grnt_), 3'b110);
        check("ch3_owner", int'(b3.Owner), 0);

        do_reset();
        r4 = 4'hf;
        l4 = 4'hf;
        r3 = 3'h7;
        l3 = 3'h7;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) r4[b] = ~r4[b];
                if ($urandom_range(0, 15) == 0) l4[b] = ~l4[b];
            end
            for (int b = 0; b < 3; b++) begin
                if ($urandom_range(0, 5) == 0) r3[b] = ~r3[b];
                if ($urandom_range(0, 15) == 0) l3[b] = ~l3[b];
            end
            cyc(r4, l4, r3, l3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
